// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and helpers for the multi-port register file
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clearState_t;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - sequential scrub sequencer: walks every register address once
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int NREG = 32,
    parameter int AW   = clog2(NREG)
) (
    input  logic          clkIn,
    input  logic          resetIn,
    input  logic          clearIn,
    output logic          busyOut,
    output logic [AW-1:0] scrubAddr,
    output logic          scrubWe
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

    clearState_t   state;
    logic [AW-1:0] cnt;

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clearIn) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    // cnt wraps to zero on the same edge the last register is scrubbed
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busyOut   = (state == CLEAR);
    assign scrubWe   = (state == CLEAR);
    assign scrubAddr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with byte-enable writes, bypass and scrub
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_R0  = 1,
    parameter int PORT_REG = NREG - 1,
    parameter int PORT_W   = 16,
    parameter int AW       = clog2(NREG)
) (
    input  logic                clkIn,
    input  logic                resetIn,
    input  logic [NRD*AW-1:0]   rsIn,
    output logic [NRD*XLEN-1:0] DataOut,
    input  logic [AW-1:0]       rdIn,
    input  logic [XLEN-1:0]     DataIn,
    input  logic                WriteIn,
    input  logic [XLEN/8-1:0]   ByteEnIn,
    input  logic                clearIn,
    output logic                busyOut,
    output logic [PORT_W-1:0]   portOut
);

    localparam int NBYTE = XLEN / 8;

    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] oldWord;
    logic [XLEN-1:0] mergedWord;
    logic [AW-1:0]   scrubAddr;
    logic            scrubWe;
    logic            rdIsZero;
    logic            writeEff;

    regfile_clear_fsm #(
        .NREG (NREG),
        .AW   (AW)
    ) uClearFsm (
        .clkIn     (clkIn),
        .resetIn   (resetIn),
        .clearIn   (clearIn),
        .busyOut   (busyOut),
        .scrubAddr (scrubAddr),
        .scrubWe   (scrubWe)
    );

    assign rdIsZero = (ZERO_R0 != 0) && (rdIn == '0);

    // A write commits only in IDLE, loses to a simultaneous clear, and never targets a hardwired r0
    assign writeEff = WriteIn && !busyOut && !clearIn && !resetIn && !rdIsZero;

    always_comb begin
        oldWord    = regs[rdIn];
        mergedWord = oldWord;
        for (int b = 0; b < NBYTE; b++) begin
            if (ByteEnIn[b]) begin
                mergedWord[b*8 +: 8] = DataIn[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= '0;
            end
        end else if (scrubWe) begin
            regs[scrubAddr] <= '0;
        end else if (writeEff) begin
            regs[rdIn] <= mergedWord;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : gRead
        logic [AW-1:0]   rsAddr;
        logic [XLEN-1:0] readData;

        assign rsAddr = rsIn[i*AW +: AW];

        always_comb begin
            if ((ZERO_R0 != 0) && (rsAddr == '0)) begin
                readData = '0;
            end else if (writeEff && (rsAddr == rdIn)) begin
                readData = mergedWord;
            end else begin
                readData = regs[rsAddr];
            end
        end

        assign DataOut[i*XLEN +: XLEN] = readData;
    end

    // Display mirror shows stored contents only, so it lags a write by one cycle
    assign portOut = regs[PORT_REG][PORT_W-1:0];

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized scoreboard bench for regfile_mp
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clkIn;
    logic                resetIn;
    logic [NRD*AW-1:0]   rsIn;
    logic [NRD*XLEN-1:0] DataOut;
    logic [AW-1:0]       rdIn;
    logic [XLEN-1:0]     DataIn;
    logic                WriteIn;
    logic [XLEN/8-1:0]   ByteEnIn;
    logic                clearIn;
    logic                busyOut;
    logic [15:0]         portOut;

    regfile_mp #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .NRD      (NRD),
        .ZERO_R0  (1),
        .PORT_REG (NREG - 1),
        .PORT_W   (16)
    ) dut (
        .clkIn    (clkIn),
        .resetIn  (resetIn),
        .rsIn     (rsIn),
        .DataOut  (DataOut),
        .rdIn     (rdIn),
        .DataIn   (DataIn),
        .WriteIn  (WriteIn),
        .ByteEnIn (ByteEnIn),
        .clearIn  (clearIn),
        .busyOut  (busyOut),
        .portOut  (portOut)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    typedef struct {
        int          tag;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        busy;
        logic [15:0] port;
    } expect_t;

    expect_t     sbQueue[$];
    int          nChecks = 0;
    int          nFails  = 0;
    int          stepNo  = 0;

    // Reference state: architectural register contents and scrub progress
    logic [31:0] mem [NREG];
    bit          mBusy;
    int          mScrubIdx;

    function automatic logic [31:0] merge(input logic [31:0] oldV, input logic [31:0] newV,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = be[b] ? newV[b*8 +: 8] : oldV[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] modelRead(input int a, input bit rst, input bit clr,
                                              input bit we, input int rd,
                                              input logic [31:0] data, input logic [3:0] be);
        if (a == 0) return 32'h0;
        if (we && !rst && !clr && !mBusy && rd != 0 && a == rd) return merge(mem[rd], data, be);
        return mem[a];
    endfunction

    task automatic step(input bit rst, input bit clr, input bit we, input int rd,
                        input logic [31:0] data, input logic [3:0] be,
                        input int rs0, input int rs1);
        expect_t e;
        resetIn  = rst;
        clearIn  = clr;
        WriteIn  = we;
        rdIn     = AW'(rd);
        DataIn   = data;
        ByteEnIn = be;
        rsIn     = {AW'(rs1), AW'(rs0)};
        e.tag  = stepNo;
        e.d0   = modelRead(rs0, rst, clr, we, rd, data, be);
        e.d1   = modelRead(rs1, rst, clr, we, rd, data, be);
        e.busy = mBusy;
        e.port = mem[NREG-1][15:0];
        sbQueue.push_back(e);
        @(posedge clkIn);
        if (rst) begin
            for (int k = 0; k < NREG; k++) mem[k] = 32'h0;
            mBusy = 0;
            mScrubIdx = 0;
        end else if (mBusy) begin
            mem[mScrubIdx] = 32'h0;
            mScrubIdx++;
            if (mScrubIdx == NREG) mBusy = 0;
        end else if (clr) begin
            mBusy = 1;
            mScrubIdx = 0;
        end else if (we && rd != 0) begin
            mem[rd] = merge(mem[rd], data, be);
        end
        stepNo++;
        #1;
    endtask

    task automatic idle(input int rs0, input int rs1);
        step(0, 0, 0, 0, 32'h0, 4'h0, rs0, rs1);
    endtask

    task automatic fillAll();
        for (int r = 0; r < NREG; r++) begin
            step(0, 0, 1, r, $urandom | 32'h0100_0001, 4'hF, r, (r + 1) % NREG);
        end
    endtask

    always @(negedge clkIn) begin
        if (sbQueue.size() > 0) begin
            expect_t e;
            e = sbQueue.pop_front();
            nChecks++;
            if (DataOut[31:0] !== e.d0) begin
                nFails++;
                $display("FAIL dataOut0 step %0d: got %h expected %h", e.tag, DataOut[31:0], e.d0);
            end
            nChecks++;
            if (DataOut[63:32] !== e.d1) begin
                nFails++;
                $display("FAIL dataOut1 step %0d: got %h expected %h", e.tag, DataOut[63:32], e.d1);
            end
            nChecks++;
            if (busyOut !== e.busy) begin
                nFails++;
                $display("FAIL busyOut step %0d: got %b expected %b", e.tag, busyOut, e.busy);
            end
            nChecks++;
            if (portOut !== e.port) begin
                nFails++;
                $display("FAIL portOut step %0d: got %h expected %h", e.tag, portOut, e.port);
            end
        end
    end

    initial begin
        int busyCycles;
        resetIn = 1; clearIn = 0; WriteIn = 0; rdIn = '0; DataIn = '0; ByteEnIn = '0; rsIn = '0;
        for (int k = 0; k < NREG; k++) mem[k] = 32'h0;
        mBusy = 0;
        mScrubIdx = 0;
        @(posedge clkIn);
        #1;
        step(1, 0, 0, 0, 32'h0, 4'h0, 3, 31);
        idle(0, 31);
        idle(7, 12);

        // Bypass of a full write, then the stored value holds
        step(0, 0, 1, 5, 32'hDEADBEEF, 4'hF, 5, 0);
        idle(5, 5);
        // Single-byte merge
        step(0, 0, 1, 5, 32'h0000_1200, 4'b0010, 5, 4);
        idle(5, 0);
        // r0 is hardwired to zero, even in the write cycle
        step(0, 0, 1, 0, 32'h0000_1234, 4'hF, 0, 0);
        idle(0, 5);
        // Display mirror lags a write by one cycle
        step(0, 0, 1, 31, 32'hABCD_5678, 4'hF, 31, 30);
        idle(31, 5);

        for (int n = 0; n < 200; n++) begin
            int rd;
            int rs0;
            rd  = $urandom_range(0, NREG - 1);
            rs0 = ($urandom_range(0, 1) == 1) ? rd : $urandom_range(0, NREG - 1);
            step(0, 0, $urandom_range(0, 3) != 0, rd, $urandom, 4'($urandom),
                 rs0, $urandom_range(0, NREG - 1));
        end

        // Full scrub with writes and re-clears attempted mid-scrub
        fillAll();
        step(0, 1, 0, 0, 32'h0, 4'h0, 9, 10);
        busyCycles = 0;
        for (int c = 0; c < NREG + 2; c++) begin
            if (mBusy) busyCycles++;
            if (c == 10) step(0, 0, 1, 20, 32'h5555_AAAA, 4'hF, 9, 10);
            else if (c == 15) step(0, 1, 1, 25, 32'h1111_2222, 4'hF, 25, 31);
            else step(0, 0, $urandom_range(0, 1), $urandom_range(0, NREG - 1), $urandom, 4'hF,
                      $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1));
        end
        nChecks++;
        if (busyCycles != NREG) begin
            nFails++;
            $display("FAIL scrubLength: got %0d expected %0d", busyCycles, NREG);
        end
        for (int r = 0; r < NREG; r += 2) idle(r, r + 1);

        // Clear and write in the same idle cycle: clear wins
        step(0, 0, 1, 7, 32'h7777_7777, 4'hF, 7, 7);
        step(0, 1, 1, 7, 32'h1234_5678, 4'hF, 7, 8);
        while (mBusy) idle($urandom_range(0, NREG - 1), 7);
        idle(7, 31);

        // Reset in the middle of a scrub
        fillAll();
        step(0, 1, 0, 0, 32'h0, 4'h0, 1, 2);
        for (int c = 0; c < 5; c++) idle(c + 10, 31);
        step(1, 1, 1, 12, 32'hFFFF_FFFF, 4'hF, 12, 31);
        for (int r = 0; r < NREG; r += 2) idle(r, r + 1);

        for (int n = 0; n < 150; n++) begin
            int rd;
            rd = $urandom_range(0, NREG - 1);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 1),
                 rd, $urandom, 4'($urandom), rd, $urandom_range(0, NREG - 1));
        end

        @(negedge clkIn);
        @(negedge clkIn);
        nChecks++;
        if (sbQueue.size() != 0) begin
            nFails++;
            $display("FAIL scoreboardDrain: got %0d pending expected 0", sbQueue.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
